// File: rtl/passcode_recorder.sv
// passcode_recorder
//   Captures an entry of NUM_KEYS distinct keys (values 1..NUM_KEYS) from
//   one-cycle keypad strobes. Out-of-range and repeated keys are rejected
//   with a pulse. A partial entry is dropped on clear or after TIMEOUT idle
//   cycles in capture. A complete entry commits atomically to passcode.
//
// Ports
//   Clk        clock, all state on posedge
//   Reset      asynchronous active-high reset
//   EN         capture enable; gates key_valid and freezes the timer
//   key_valid  one-cycle strobe qualifying key_val
//   key_val    key value
//   clear      synchronous abort of the partial entry, independent of EN
//   passcode   committed code, digit i at [i*KEY_W +: KEY_W]
//   seen_mask  bit k-1 set once key k is accepted in the current entry
//   count      keys accepted in the current entry
//   code_valid one-cycle pulse, passcode just updated
//   dup_err    one-cycle pulse, repeated key rejected
//   range_err  one-cycle pulse, key_val was 0 or above NUM_KEYS
//   timeout    one-cycle pulse, entry aborted by the idle timer
module passcode_recorder #(
    parameter int NUM_KEYS = 12,
    parameter int KEY_W    = 4,
    parameter int TIMEOUT  = 0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          EN,
    input  logic                          key_valid,
    input  logic [KEY_W-1:0]              key_val,
    input  logic                          clear,
    output logic [NUM_KEYS*KEY_W-1:0]     passcode,
    output logic [NUM_KEYS-1:0]           seen_mask,
    output logic [$clog2(NUM_KEYS+1)-1:0] count,
    output logic                          code_valid,
    output logic                          dup_err,
    output logic                          range_err,
    output logic                          timeout
);

    localparam int CW = $clog2(NUM_KEYS + 1);
    // A disabled timer still needs a legal one-bit register.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PW = NUM_KEYS * KEY_W;

    localparam logic [KEY_W-1:0] KEY_MAX    = KEY_W'(NUM_KEYS);
    localparam logic [CW-1:0]    LAST_IDX   = CW'(NUM_KEYS - 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    function automatic logic [PW-1:0] reset_code();
        logic [PW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            c[i*KEY_W +: KEY_W] = KEY_W'(i + 1);
        end
        return c;
    endfunction

    localparam logic [PW-1:0] RESET_CODE = reset_code();

    typedef enum logic {
        S_IDLE,
        S_CAPTURE
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       buf_q;
    logic [PW-1:0]       passcode_q;
    logic [NUM_KEYS-1:0] seen_mask_q;
    logic [CW-1:0]       count_q;
    logic [TW-1:0]       timer_q;
    logic                code_valid_q;
    logic                dup_err_q;
    logic                range_err_q;
    logic                timeout_q;

    logic                key_ev_d;
    logic                in_range_d;
    logic [NUM_KEYS-1:0] key_bit_d;
    logic                dup_d;
    logic [PW-1:0]       commit_d;
    logic                timer_run_d;
    logic                timer_hit_d;

    always_comb begin
        key_ev_d   = key_valid & EN;
        in_range_d = (key_val != '0) && (key_val <= KEY_MAX);
        key_bit_d  = '0;
        if (in_range_d) begin
            key_bit_d = NUM_KEYS'(1) << (key_val - KEY_W'(1));
        end
        dup_d = |(seen_mask_q & key_bit_d);
        // Completed code: buffered digits plus the completing key in the top slot.
        commit_d = buf_q;
        commit_d[(NUM_KEYS-1)*KEY_W +: KEY_W] = key_val;
        timer_run_d = (TIMEOUT > 0) && (state_q == S_CAPTURE) && EN;
        // Hit on the edge that would take the idle count to TIMEOUT.
        timer_hit_d = timer_run_d && (timer_q == TIMER_LAST);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            passcode_q   <= RESET_CODE;
            seen_mask_q  <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            code_valid_q <= 1'b0;
            dup_err_q    <= 1'b0;
            range_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            dup_err_q    <= 1'b0;
            range_err_q  <= 1'b0;
            timeout_q    <= 1'b0;

            if (clear) begin
                state_q     <= S_IDLE;
                buf_q       <= '0;
                seen_mask_q <= '0;
                count_q     <= '0;
                timer_q     <= '0;
            end else if (key_ev_d) begin
                timer_q <= '0;
                if (!in_range_d) begin
                    range_err_q <= 1'b1;
                end else if (dup_d) begin
                    dup_err_q <= 1'b1;
                end else if (count_q == LAST_IDX) begin
                    passcode_q   <= commit_d;
                    code_valid_q <= 1'b1;
                    state_q      <= S_IDLE;
                    buf_q        <= '0;
                    seen_mask_q  <= '0;
                    count_q      <= '0;
                end else begin
                    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                        if (count_q == CW'(i)) begin
                            buf_q[i*KEY_W +: KEY_W] <= key_val;
                        end
                    end
                    seen_mask_q <= seen_mask_q | key_bit_d;
                    count_q     <= count_q + CW'(1);
                    state_q     <= S_CAPTURE;
                end
            end else if (timer_hit_d) begin
                state_q     <= S_IDLE;
                buf_q       <= '0;
                seen_mask_q <= '0;
                count_q     <= '0;
                timer_q     <= '0;
                timeout_q   <= 1'b1;
            end else if (timer_run_d) begin
                // Below TIMER_LAST here, so the increment cannot wrap.
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign passcode   = passcode_q;
    assign seen_mask  = seen_mask_q;
    assign count      = count_q;
    assign code_valid = code_valid_q;
    assign dup_err    = dup_err_q;
    assign range_err  = range_err_q;
    assign timeout    = timeout_q;

endmodule
